median_line_sched: RTL and testbench

- Line scheduler that sequences a 1-D median filter core over one line of pixels per start pulse.
- Accepts pixels on a valid/ready stream and drives the core's pixel input and push enable.
- Replicates edge pixels so the core sees full windows at the line borders, then drains the core pipeline.
- Emits exactly LINE_LEN medians with aligned valid/last flags. Sits between the pixel source and the median core.

---
 rtl/median_line_sched.sv | 147 ++++++++++++++
 tb/tb_median_line_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_line_sched.sv
// Line scheduler for a 1-D median core: primes the window with the first pixel,
// streams the line, replicates the last pixel, drains the core and tags its medians.
module median_line_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter int WINDOW_SIZE  = 3,
  parameter int LINE_LEN     = 640,
  parameter int CORE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] core_pixel,
  output logic                  core_en,
  input  logic [DATA_WIDTH-1:0] core_median,
  output logic [DATA_WIDTH-1:0] m_median,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int H     = WINDOW_SIZE / 2;
  localparam int TOTAL = LINE_LEN + 2 * H;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int DCW   = $clog2(CORE_LATENCY + 1);

  localparam logic [CW-1:0]  IDX_VAL     = CW'(2 * H);
  localparam logic [CW-1:0]  IDX_LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0]  IDX_END     = CW'(TOTAL);
  localparam logic [CW-1:0]  IDX_PAD     = CW'(H);
  localparam logic [CW-1:0]  IDX_RUN_END = CW'(LINE_LEN + H - 1);
  localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(CORE_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DRAIN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           push_idx;
  logic [DCW-1:0]          drain_cnt;
  logic [DATA_WIDTH-1:0]   edge_pix;
  logic [CORE_LATENCY-1:0] tag_val;
  logic [CORE_LATENCY-1:0] tag_last;

  logic accept;
  logic push;
  logic tag_val_in;
  logic tag_last_in;

  // The core must advance in the very cycle a pixel is accepted, so the push
  // strobe is decoded from the registered state and the live handshake.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    push   = 1'b0;
    accept = s_valid & s_ready;
    case (state)
      PRIME:        push = s_ready ? accept : 1'b1;
      RUN:          push = accept;
      FLUSH, DRAIN: push = 1'b1;
      default:      push = 1'b0;
    endcase
    core_en     = push;
    core_pixel  = accept ? s_pixel : edge_pix;
    // Drain pushes sit at IDX_END, so they carry val=0 without a special case.
    tag_val_in  = (push_idx >= IDX_VAL) && (push_idx < IDX_END);
    tag_last_in = (push_idx == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      push_idx  <= '0;
      drain_cnt <= '0;
      edge_pix  <= '0;
      tag_val   <= '0;
      tag_last  <= '0;
      s_ready   <= 1'b0;
      m_median  <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every read
      // in this block sees the pre-edge value regardless of statement order.
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;

      if (push) begin
        tag_val  <= (tag_val << 1) | CORE_LATENCY'(tag_val_in);
        tag_last <= (tag_last << 1) | CORE_LATENCY'(tag_last_in);
        m_valid  <= tag_val[CORE_LATENCY-1];
        m_last   <= tag_val[CORE_LATENCY-1] & tag_last[CORE_LATENCY-1];
        if (tag_val[CORE_LATENCY-1]) m_median <= core_median;
        if (push_idx != IDX_END) push_idx <= push_idx + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= PRIME;
            busy      <= 1'b1;
            s_ready   <= 1'b1;
            push_idx  <= '0;
            drain_cnt <= '0;
          end
        end
        PRIME: begin
          if (s_ready) begin
            if (accept) begin
              edge_pix <= s_pixel;
              s_ready  <= 1'b0;
            end
          end else if (push_idx == IDX_PAD) begin
            state   <= (LINE_LEN == 1) ? FLUSH : RUN;
            s_ready <= (LINE_LEN != 1);
          end
        end
        RUN: begin
          if (accept) begin
            edge_pix <= s_pixel;
            if (push_idx == IDX_RUN_END) begin
              state   <= FLUSH;
              s_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (push_idx == IDX_LAST) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_line_sched.sv
// Bench for median_line_sched: three configurations, each with a behavioural median
// core; every line is compared against medians computed directly from the padded line.
module tb_median_line_sched;

  localparam int NI = 3;
  localparam int W_[NI]   = '{3, 3, 5};
  localparam int LEN_[NI] = '{4, 1, 6};
  localparam int LAT_[NI] = '{2, 2, 3};

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start[NI];
  logic       s_valid[NI];
  logic [7:0] s_pixel[NI];
  logic       s_ready[NI];
  logic       core_en[NI];
  logic [7:0] core_pixel[NI];
  logic [7:0] core_median[NI];
  logic [7:0] m_median[NI];
  logic       m_valid[NI];
  logic       m_last[NI];
  logic       busy[NI];
  logic       done[NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    median_line_sched #(
      .DATA_WIDTH  (8),
      .WINDOW_SIZE (W_[g]),
      .LINE_LEN    (LEN_[g]),
      .CORE_LATENCY(LAT_[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .s_pixel    (s_pixel[g]),
      .s_valid    (s_valid[g]),
      .s_ready    (s_ready[g]),
      .core_pixel (core_pixel[g]),
      .core_en    (core_en[g]),
      .core_median(core_median[g]),
      .m_median   (m_median[g]),
      .m_valid    (m_valid[g]),
      .m_last     (m_last[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int med_of(input int q[$]);
    int s[$];
    s = q;
    s.sort();
    return s[s.size() / 2];
  endfunction

  // Reference: pad the line with H copies of each border pixel, slide a W window.
  function automatic void ref_line(input int w, input int pix[$], output int pad[$],
                                   output int med[$]);
    int h = w / 2;
    pad = {};
    med = {};
    repeat (h) pad.push_back(pix[0]);
    foreach (pix[i]) pad.push_back(pix[i]);
    repeat (h) pad.push_back(pix[pix.size() - 1]);
    for (int i = 0; i + w <= pad.size(); i++) begin
      int win[$];
      for (int j = 0; j < w; j++) win.push_back(pad[i + j]);
      med.push_back(med_of(win));
    end
  endfunction

  function automatic iq_t rand_line(input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255)));
    return q;
  endfunction

  // Behavioural core: shifts on core_en; median of the new window appears on
  // core_median after CORE_LATENCY pushes in total.
  int win_q[NI][$];
  int lat_q[NI][$];
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (core_en[k]) begin
        win_q[k].push_back(int'(core_pixel[k]));
        if (win_q[k].size() > W_[k]) void'(win_q[k].pop_front());
        lat_q[k].push_back(med_of(win_q[k]));
        if (lat_q[k].size() >= LAT_[k]) core_median[k] <= 8'(lat_q[k].pop_front());
      end
    end
  end

  // Observation at the falling edge, away from the active edge.
  int cyc = 0;
  int pushes[NI][$];
  int outs[NI][$];
  int lasts[NI][$];
  int n_done[NI];
  int n_stray[NI];
  int done_cyc[NI];
  int push_cyc[NI];
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (core_en[k]) begin
        pushes[k].push_back(int'(core_pixel[k]));
        push_cyc[k] = cyc;
      end
      if (m_valid[k]) begin
        outs[k].push_back(int'(m_median[k]));
        lasts[k].push_back(int'(m_last[k]));
      end
      if (m_last[k] && !m_valid[k]) n_stray[k]++;
      if (done[k]) begin
        n_done[k]++;
        done_cyc[k] = cyc;
      end
    end
  end

  // Streams one line into instance k; hold_at forces a 3-cycle s_valid gap once
  // that many pixels are accepted; poke pulses start in RUN and in the done cycle.
  task automatic run_line(input int k, input int pix[$], input int gap_pct,
                          input int hold_at, input bit poke, input string nm);
    int b_push  = pushes[k].size();
    int b_out   = outs[k].size();
    int b_done  = n_done[k];
    int b_stray = n_stray[k];
    int pad[$];
    int med[$];
    int idx   = 0;
    int guard = 0;
    int holds = 0;
    int n_out;
    bit acc;
    ref_line(W_[k], pix, pad, med);
    for (int i = 0; i < LAT_[k]; i++) pad.push_back(pix[pix.size() - 1]);

    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    while (idx < pix.size() && guard < 4000) begin
      if (idx == hold_at && holds < 3) begin
        s_valid[k] = 1'b0;
        holds++;
      end else begin
        s_valid[k] = ($urandom_range(99) >= gap_pct);
      end
      s_pixel[k] = s_valid[k] ? 8'(pix[idx]) : 8'($urandom_range(255));
      start[k]   = poke && (idx == 2);
      @(negedge clk);
      acc = s_valid[k] && s_ready[k];
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    start[k]   = 1'b0;
    s_valid[k] = 1'b0;
    check({nm, ":accepted"}, idx, pix.size());

    guard = 0;
    while (!done[k] && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check({nm, ":done_seen"}, done[k], 1);
    check({nm, ":busy_in_done"}, busy[k], 0);
    if (poke) start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    repeat (3) @(negedge clk);
    check({nm, ":idle_ready"}, s_ready[k], 0);
    check({nm, ":idle_busy"}, busy[k], 0);

    check({nm, ":n_push"}, pushes[k].size() - b_push, pad.size());
    for (int i = 0; i < pad.size() && b_push + i < pushes[k].size(); i++)
      check($sformatf("%s:push%0d", nm, i), pushes[k][b_push + i], pad[i]);
    n_out = outs[k].size() - b_out;
    check({nm, ":n_out"}, n_out, LEN_[k]);
    for (int i = 0; i < med.size() && i < n_out; i++) begin
      check($sformatf("%s:med%0d", nm, i), outs[k][b_out + i], med[i]);
      check($sformatf("%s:last%0d", nm, i), lasts[k][b_out + i], (i == n_out - 1) ? 1 : 0);
    end
    check({nm, ":n_done"}, n_done[k] - b_done, 1);
    check({nm, ":done_after_drain"}, done_cyc[k] - push_cyc[k], 1);
    check({nm, ":stray_last"}, n_stray[k] - b_stray, 0);
  endtask

  initial begin
    int line[$];
    int idx;
    int guard;
    int b_out;
    int b_done;
    bit acc;
    for (int k = 0; k < NI; k++) begin
      start[k]   = 1'b0;
      s_valid[k] = 1'b0;
      s_pixel[k] = 8'd0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst:s_ready", s_ready[0], 0);
    check("rst:core_en", core_en[0], 0);
    check("rst:core_pixel", core_pixel[0], 0);
    check("rst:m_median", m_median[0], 0);
    check("rst:m_valid", m_valid[0], 0);
    check("rst:m_last", m_last[0], 0);
    check("rst:busy", busy[0], 0);
    check("rst:done", done[0], 0);
    check("rst:busy_c", busy[2], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle instance ignores traffic without a start.
    s_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle:no_start_ready", s_ready[0], 0);
    s_valid[0] = 1'b0;

    line = {10, 50, 20, 30};
    run_line(0, line, 0, -1, 1'b0, "a_line");
    run_line(0, line, 0, 2, 1'b0, "a_gap");
    line = {77};
    run_line(1, line, 0, -1, 1'b0, "b_one");
    line = {9, 1, 8, 2, 7, 3};
    run_line(2, line, 0, -1, 1'b0, "c_line");

    // Abort a line after two accepted pixels.
    b_out  = outs[0].size();
    b_done = n_done[0];
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    idx   = 0;
    guard = 0;
    while (idx < 2 && guard < 100) begin
      s_valid[0] = 1'b1;
      s_pixel[0] = 8'($urandom_range(1, 255));
      @(negedge clk);
      acc = s_valid[0] && s_ready[0];
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    check("abort:accepted", idx, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort:s_ready", s_ready[0], 0);
    check("abort:busy", busy[0], 0);
    check("abort:core_en", core_en[0], 0);
    check("abort:core_pixel", core_pixel[0], 0);
    check("abort:m_median", m_median[0], 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    check("abort:no_out", outs[0].size() - b_out, 0);
    check("abort:no_done", n_done[0] - b_done, 0);
    check("abort:idle_ready", s_ready[0], 0);

    run_line(0, rand_line(LEN_[0]), 0, -1, 1'b0, "a_after_abort");
    run_line(0, rand_line(LEN_[0]), 20, -1, 1'b1, "a_poke");

    for (int r = 0; r < 6; r++)
      for (int k = 0; k < NI; k++)
        run_line(k, rand_line(LEN_[k]), 35, -1, r[0], $sformatf("rnd%0d_%0d", r, k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
